// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier -- unsigned radix-2 shift-add multiplier, one multiplier bit
// per clock, with a start/busy/done handshake.
//
// Also contains fast_adder, the block-carry-lookahead adder used as the
// accumulate stage.
//
// seq_multiplier ports
//   clk    in   1              clock, all state changes on posedge
//   reset  in   1              asynchronous active-low reset
//   start  in   1              sample A/B and begin; honoured only when busy=0
//   A      in   word_width     multiplicand (unsigned)
//   B      in   word_width     multiplier (unsigned)
//   busy   out  1              high while the shift-add loop is running
//   done   out  1              one-cycle pulse, PROD valid
//   PROD   out  2*word_width   product, held until the next result
//
// fast_adder ports
//   A, B   in   word_width     addends
//   C_IN   in   1              carry in
//   R      out  word_width     sum
//   C_OUT  out  1              carry out
// -----------------------------------------------------------------------------

module fast_adder #(
    parameter int word_width   = 16,
    parameter int cascade_size = 4
) (
    input  logic [word_width-1:0] A,
    input  logic [word_width-1:0] B,
    input  logic                  C_IN,
    output logic [word_width-1:0] R,
    output logic                  C_OUT
);
    localparam int NGRP = word_width / cascade_size;

    logic [word_width-1:0] w_g;
    logic [word_width-1:0] w_p;

    assign w_g = A & B;
    assign w_p = A ^ B;

    // Carries ripple inside a group; each group's carry-out is formed from
    // the group generate/propagate terms so the inter-group chain is one
    // AND-OR per group.
    always_comb begin
        logic        v_gc;
        logic        v_gg;
        logic        v_gp;
        logic        v_c;
        int unsigned v_idx;
        R     = '0;
        v_gc  = C_IN;
        v_gg  = 1'b0;
        v_gp  = 1'b1;
        v_c   = 1'b0;
        v_idx = 0;
        for (int unsigned grp = 0; grp < NGRP; grp++) begin
            v_gg = 1'b0;
            v_gp = 1'b1;
            v_c  = v_gc;
            for (int unsigned k = 0; k < cascade_size; k++) begin
                v_idx    = grp * cascade_size + k;
                R[v_idx] = w_p[v_idx] ^ v_c;
                v_c      = w_g[v_idx] | (w_p[v_idx] & v_c);
                v_gg     = w_g[v_idx] | (w_p[v_idx] & v_gg);
                v_gp     = v_gp & w_p[v_idx];
            end
            v_gc = v_gg | (v_gp & v_gc);
        end
        C_OUT = v_gc;
    end
endmodule

module seq_multiplier #(
    parameter int word_width   = 16,
    parameter int cascade_size = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [word_width-1:0]   A,
    input  logic [word_width-1:0]   B,
    output logic                    busy,
    output logic                    done,
    output logic [2*word_width-1:0] PROD
);
    localparam int               CNT_W    = $clog2(word_width) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(word_width - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [word_width-1:0]   r_m;
    logic [word_width-1:0]   r_hi;
    logic [word_width-1:0]   r_lo;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_busy;
    logic                    r_done;
    logic [2*word_width-1:0] r_prod;

    logic [word_width-1:0]   w_sum;
    logic                    w_cout;
    logic [word_width:0]     w_acc;

    fast_adder #(
        .word_width   (word_width),
        .cascade_size (cascade_size)
    ) u_fast_adder (
        .A     (r_hi),
        .B     (r_m),
        .C_IN  (1'b0),
        .R     (w_sum),
        .C_OUT (w_cout)
    );

    // {carry, sum} of this step; the carry becomes the new hi MSB after the
    // shift, so the partial product never overflows.
    assign w_acc = r_lo[0] ? {w_cout, w_sum} : {1'b0, r_hi};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_m     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_prod  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m     <= A;
                        r_lo    <= B;
                        r_hi    <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_hi  <= w_acc[word_width:1];
                    r_lo  <= {w_acc[0], r_lo[word_width-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Registered outputs: the pulse and product appear on
                    // the edge that leaves DONE, which is also the edge a
                    // new start is accepted on.
                    r_done <= 1'b1;
                    r_prod <= {r_hi, r_lo};
                    if (start) begin
                        r_m     <= A;
                        r_lo    <= B;
                        r_hi    <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign PROD = r_prod;
endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;
    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [31:0] PROD;

    int checks;
    int failures;

    seq_multiplier #(
        .word_width   (16),
        .cascade_size (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .PROD  (PROD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the product is plain unsigned arithmetic.
    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] x;
        logic [31:0] y;
        x = {16'h0, a};
        y = {16'h0, b};
        return x * y;
    endfunction

    // Launch one operation and observe it: edges from acceptance to done,
    // busy-high samples, and the product shown with done.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output int lat, output int bcnt, output logic [31:0] p);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy === 1'b1) bcnt++;
        end
        p = PROD;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags busy/done=%b required 00", {busy, done});
        end
        checks++;
        if (PROD !== 32'h0) begin
            failures++;
            $display("FAIL reset_prod PROD=%h required 00000000", PROD);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_zero_operand();
        int lat, bcnt;
        logic [31:0] p;
        run_op(16'h0000, 16'hFFFF, lat, bcnt, p);
        checks++;
        if (lat !== 17) begin
            failures++;
            $display("FAIL zero_latency got=%0d required 17", lat);
        end
        checks++;
        if (p !== 32'h0) begin
            failures++;
            $display("FAIL zero_prod got=%h required 00000000", p);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_one_cycle done=%b required 0", done);
        end
    endtask

    task automatic test_max_operands();
        int lat, bcnt;
        logic [31:0] p;
        run_op(16'hFFFF, 16'hFFFF, lat, bcnt, p);
        checks++;
        if (p !== ref_mul(16'hFFFF, 16'hFFFF)) begin
            failures++;
            $display("FAIL max_prod got=%h required %h", p, ref_mul(16'hFFFF, 16'hFFFF));
        end
        checks++;
        if (lat !== 17) begin
            failures++;
            $display("FAIL max_latency got=%0d required 17", lat);
        end
        checks++;
        if (bcnt !== 16) begin
            failures++;
            $display("FAIL max_busy_cycles got=%0d required 16", bcnt);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (PROD !== 32'hFFFE0001) begin
            failures++;
            $display("FAIL prod_held_idle got=%h required fffe0001", PROD);
        end
    endtask

    task automatic test_operand_hold();
        int lat;
        @(negedge clk);
        A = 16'd1234;
        B = 16'd5678;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 5) begin
                A = 16'h5A5A;
                B = 16'hA5A5;
                checks++;
                if (PROD !== 32'hFFFE0001) begin
                    failures++;
                    $display("FAIL prod_during_run got=%h required fffe0001", PROD);
                end
            end
        end
        checks++;
        if (PROD !== ref_mul(16'd1234, 16'd5678) || lat !== 17) begin
            failures++;
            $display("FAIL operand_hold got=%h lat=%0d required %h lat=17",
                     PROD, lat, ref_mul(16'd1234, 16'd5678));
        end
    endtask

    task automatic test_start_ignored();
        int lat, ndone;
        @(negedge clk);
        A = 16'd3;
        B = 16'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        ndone = 0;
        // Keep watching 15 edges past the expected done to catch a second one.
        while (lat < 32) begin
            if (lat == 4 || lat == 9) begin
                A = 16'd7;
                B = 16'd7;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (done === 1'b1) begin
                ndone++;
                checks++;
                if (PROD !== ref_mul(16'd3, 16'd5) || lat !== 17) begin
                    failures++;
                    $display("FAIL start_ignored_prod got=%h lat=%0d required %h lat=17",
                             PROD, lat, ref_mul(16'd3, 16'd5));
                end
            end
        end
        start = 1'b0;
        checks++;
        if (ndone !== 1) begin
            failures++;
            $display("FAIL start_ignored_done_count got=%0d required 1", ndone);
        end
    endtask

    task automatic test_async_reset();
        int lat, bcnt;
        logic [31:0] p;
        @(negedge clk);
        A = 16'hABCD;
        B = 16'h1234;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, done} !== 2'b00 || PROD !== 32'h0) begin
            failures++;
            $display("FAIL async_reset busy=%b done=%b PROD=%h required 0 0 00000000",
                     busy, done, PROD);
        end
        @(negedge clk);
        reset = 1'b1;
        lat = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) lat++;
        end
        checks++;
        if (lat !== 0) begin
            failures++;
            $display("FAIL abort_no_activity got=%0d active cycles required 0", lat);
        end
        run_op(16'd2, 16'd3, lat, bcnt, p);
        checks++;
        if (p !== ref_mul(16'd2, 16'd3) || lat !== 17) begin
            failures++;
            $display("FAIL after_reset_prod got=%h lat=%0d required %h lat=17",
                     p, lat, ref_mul(16'd2, 16'd3));
        end
    endtask

    task automatic test_back_to_back();
        int t, t1, t2;
        logic [31:0] p1, p2;
        t1 = -1;
        t2 = -1;
        p1 = '0;
        p2 = '0;
        @(negedge clk);
        A = 16'h8000;
        B = 16'h0002;
        start = 1'b1;
        @(posedge clk);
        #1;
        A = 16'h0001;
        B = 16'h0001;
        t = 0;
        while (t2 < 0 && t < 60) begin
            @(posedge clk);
            #1;
            t++;
            if (done === 1'b1) begin
                if (t1 < 0) begin
                    t1 = t;
                    p1 = PROD;
                    start = 1'b0;
                end else begin
                    t2 = t;
                    p2 = PROD;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (p1 !== ref_mul(16'h8000, 16'h0002) || t1 !== 17) begin
            failures++;
            $display("FAIL b2b_first got=%h t=%0d required %h t=17",
                     p1, t1, ref_mul(16'h8000, 16'h0002));
        end
        checks++;
        if (p2 !== ref_mul(16'h0001, 16'h0001) || t2 - t1 !== 17) begin
            failures++;
            $display("FAIL b2b_second got=%h spacing=%0d required %h spacing=17",
                     p2, t2 - t1, ref_mul(16'h0001, 16'h0001));
        end
    endtask

    task automatic test_random();
        int lat, bcnt;
        logic [31:0] p;
        logic [15:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (i == 0) a = 16'h0001;
            if (i == 1) b = 16'h0000;
            if (i == 2) b = 16'h8000;
            run_op(a, b, lat, bcnt, p);
            checks++;
            if (p !== ref_mul(a, b) || lat !== 17 || bcnt !== 16) begin
                failures++;
                $display("FAIL random_%0d a=%h b=%h got=%h lat=%0d busy=%0d required %h lat=17 busy=16",
                         i, a, b, p, lat, bcnt, ref_mul(a, b));
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_zero_operand();
        test_max_operands();
        test_operand_hold();
        test_start_ignored();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
